// File: rtl/p_enc_scan_if.sv
// p_enc_scan_if: valid/ready bundle for the p_enc_scan priority encoder.
//   Request side : in_valid, in_ready, in_vec[N-1:0], mode
//   Result side  : out_valid, out_ready, out_idx[W-1:0], out_last, out_none
// Modports:
//   master : the producer/consumer around the encoder (drives requests, takes beats)
//   slave  : the encoder itself
interface p_enc_scan_if #(
   parameter int N = 8
) ();
   localparam int W = $clog2(N);

   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_vec;
   logic         mode;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_idx;
   logic         out_last;
   logic         out_none;

   modport master (
      output in_valid, in_vec, mode, out_ready,
      input  in_ready, out_valid, out_idx, out_last, out_none
   );

   modport slave (
      input  in_valid, in_vec, mode, out_ready,
      output in_ready, out_valid, out_idx, out_last, out_none
   );
endinterface

// File: rtl/p_enc_scan.sv
// p_enc_scan: registered priority encoder with valid/ready on both sides.
// Accepts an N-bit request vector and reports the index of its highest set
// bit. In scan mode (mode=1) every remaining set bit is then emitted, highest
// to lowest, one index per output handshake. An all-zero vector yields one
// beat with out_none=1, out_idx=0.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : p_enc_scan_if.slave (in_valid/in_ready/in_vec/mode,
//          out_valid/out_ready/out_idx/out_last/out_none)
module p_enc_scan #(
   parameter int N = 8
) (
   input  logic          clk,
   input  logic          rst,
   p_enc_scan_if.slave   bus
);
   localparam int W = $clog2(N);

   typedef enum logic {IDLE, EMIT} state_t;
   typedef logic [N-1:0] vec_t;
   typedef logic [W-1:0] idx_t;

   // Index of the highest set bit; 0 for an all-zero vector.
   function automatic idx_t msb_idx(input vec_t v);
      idx_t r;
      r = '0;
      for (int i = 0; i < N; i++) begin
         if (v[i]) r = idx_t'(i);
      end
      return r;
   endfunction

   function automatic vec_t clr_bit(input vec_t v, input idx_t i);
      return v & ~(vec_t'(1) << i);
   endfunction

   state_t state_q, state_d;
   vec_t   pending_q, pending_d;
   logic   mode_q, mode_d;
   idx_t   idx_q, idx_d;
   logic   last_q, last_d;
   logic   none_q, none_d;
   logic   accept;

   // in_ready is gated by rst directly so it is low for the whole reset
   // pulse and rises combinationally on release.
   assign bus.in_ready  = (state_q == IDLE) && !rst;
   assign bus.out_valid = (state_q == EMIT);
   assign bus.out_idx   = idx_q;
   assign bus.out_last  = last_q;
   assign bus.out_none  = none_q;

   assign accept = bus.in_valid && bus.in_ready;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned; otherwise synthesis infers a latch to hold the old value.
      state_d   = state_q;
      pending_d = pending_q;
      mode_d    = mode_q;
      idx_d     = idx_q;
      last_d    = last_q;
      none_d    = none_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d   = EMIT;
               mode_d    = bus.mode;
               idx_d     = msb_idx(bus.in_vec);
               pending_d = clr_bit(bus.in_vec, idx_d);
               none_d    = (bus.in_vec == '0);
               // Nothing left after removing the top bit means one set bit
               // (or none at all), so this first beat is already the last.
               last_d    = !bus.mode || (pending_d == '0);
            end
         end
         EMIT: begin
            if (bus.out_ready) begin
               if (last_q || !mode_q) begin
                  state_d   = IDLE;
                  pending_d = '0;
               end else begin
                  idx_d     = msb_idx(pending_q);
                  pending_d = clr_bit(pending_q, idx_d);
                  last_d    = (pending_d == '0);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its pre-edge inputs, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= '0;
         mode_q    <= 1'b0;
         idx_q     <= '0;
         last_q    <= 1'b0;
         none_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         mode_q    <= mode_d;
         idx_q     <= idx_d;
         last_q    <= last_d;
         none_q    <= none_d;
      end
   end
endmodule

// File: tb/tb_p_enc_scan.sv
// tb_p_enc_scan: directed, table-driven bench for p_enc_scan (N=8 and N=5).
module tb_p_enc_scan;
   logic clk;
   logic rst;

   p_enc_scan_if #(.N(8)) bus8 ();
   p_enc_scan_if #(.N(5)) bus5 ();

   p_enc_scan #(.N(8)) u8 (.clk(clk), .rst(rst), .bus(bus8));
   p_enc_scan #(.N(5)) u5 (.clk(clk), .rst(rst), .bus(bus5));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests;
   int fails;

   // Expected beat b index is beats[4*b +: 3] (one nibble per beat).
   typedef struct {
      logic [7:0]  vec;
      logic        mode;
      int          nb;
      logic        none;
      logic [31:0] beats;
   } vec_rec_t;

   vec_rec_t tv [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a vector on the N=8 instance and check every beat with out_ready high.
   task automatic run8(input logic [7:0] vec, input logic mode, input int nb,
                       input logic none, input logic [31:0] beats, input string tag);
      int cnt;
      logic [31:0] e;
      bus8.in_vec    = vec;
      bus8.mode      = mode;
      bus8.out_ready = 1'b1;
      bus8.in_valid  = 1'b1;
      cnt = 0;
      while (!bus8.in_ready && cnt < 20) begin
         tick();
         cnt++;
      end
      check({tag, ".in_ready"}, 32'(bus8.in_ready), 32'd1);
      tick();
      bus8.in_valid = 1'b0;
      for (int b = 0; b < nb; b++) begin
         e = 32'(beats[4*b +: 3]);
         check($sformatf("%s.b%0d.valid", tag, b), 32'(bus8.out_valid), 32'd1);
         check($sformatf("%s.b%0d.idx", tag, b), 32'(bus8.out_idx), e);
         check($sformatf("%s.b%0d.last", tag, b), 32'(bus8.out_last), 32'(b == nb - 1));
         check($sformatf("%s.b%0d.none", tag, b), 32'(bus8.out_none), 32'(none));
         tick();
      end
      check({tag, ".done.valid"}, 32'(bus8.out_valid), 32'd0);
      check({tag, ".done.in_ready"}, 32'(bus8.in_ready), 32'd1);
   endtask

   task automatic run5(input logic [4:0] vec, input int nb, input logic [31:0] beats,
                       input string tag);
      int cnt;
      bus5.in_vec    = vec;
      bus5.mode      = 1'b1;
      bus5.out_ready = 1'b1;
      bus5.in_valid  = 1'b1;
      cnt = 0;
      while (!bus5.in_ready && cnt < 20) begin
         tick();
         cnt++;
      end
      check({tag, ".in_ready"}, 32'(bus5.in_ready), 32'd1);
      tick();
      bus5.in_valid = 1'b0;
      for (int b = 0; b < nb; b++) begin
         check($sformatf("%s.b%0d.valid", tag, b), 32'(bus5.out_valid), 32'd1);
         check($sformatf("%s.b%0d.idx", tag, b), 32'(bus5.out_idx), 32'(beats[4*b +: 3]));
         check($sformatf("%s.b%0d.last", tag, b), 32'(bus5.out_last), 32'(b == nb - 1));
         tick();
      end
      check({tag, ".done.valid"}, 32'(bus5.out_valid), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tests = 0;
      fails = 0;
      tv[0] = '{vec: 8'b1010_0101, mode: 1'b1, nb: 4, none: 1'b0, beats: 32'h0000_0257};
      tv[1] = '{vec: 8'b1010_0101, mode: 1'b0, nb: 1, none: 1'b0, beats: 32'h0000_0007};
      tv[2] = '{vec: 8'b0000_0001, mode: 1'b0, nb: 1, none: 1'b0, beats: 32'h0000_0000};
      tv[3] = '{vec: 8'h00,        mode: 1'b1, nb: 1, none: 1'b1, beats: 32'h0000_0000};
      tv[4] = '{vec: 8'h80,        mode: 1'b1, nb: 1, none: 1'b0, beats: 32'h0000_0007};
      tv[5] = '{vec: 8'h00,        mode: 1'b0, nb: 1, none: 1'b1, beats: 32'h0000_0000};
      tv[6] = '{vec: 8'b0001_1000, mode: 1'b1, nb: 2, none: 1'b0, beats: 32'h0000_0034};

      rst = 1'b1;
      bus8.in_valid = 1'b0; bus8.in_vec = '0; bus8.mode = 1'b0; bus8.out_ready = 1'b1;
      bus5.in_valid = 1'b0; bus5.in_vec = '0; bus5.mode = 1'b0; bus5.out_ready = 1'b1;

      // Reset values while rst is held.
      #2;
      check("rst.in_ready", 32'(bus8.in_ready), 32'd0);
      check("rst.out_valid", 32'(bus8.out_valid), 32'd0);
      check("rst.out_idx", 32'(bus8.out_idx), 32'd0);
      check("rst.out_last", 32'(bus8.out_last), 32'd0);
      check("rst.out_none", 32'(bus8.out_none), 32'd0);
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("rel.in_ready", 32'(bus8.in_ready), 32'd1);
      check("rel.out_valid", 32'(bus8.out_valid), 32'd0);

      for (int i = 0; i < 7; i++) begin
         run8(tv[i].vec, tv[i].mode, tv[i].nb, tv[i].none, tv[i].beats,
              $sformatf("tv%0d", i));
      end

      // Backpressure: first beat held for 3 cycles, in_valid pulses ignored.
      bus8.in_vec    = 8'b1100_0000;
      bus8.mode      = 1'b1;
      bus8.out_ready = 1'b0;
      bus8.in_valid  = 1'b1;
      check("bp.in_ready", 32'(bus8.in_ready), 32'd1);
      tick();
      bus8.in_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check($sformatf("bp.c%0d.valid", c), 32'(bus8.out_valid), 32'd1);
         check($sformatf("bp.c%0d.idx", c), 32'(bus8.out_idx), 32'd7);
         check($sformatf("bp.c%0d.last", c), 32'(bus8.out_last), 32'd0);
         check($sformatf("bp.c%0d.in_ready", c), 32'(bus8.in_ready), 32'd0);
         bus8.in_vec   = 8'h01;
         bus8.in_valid = (c != 1);
         tick();
      end
      bus8.in_valid = 1'b0;
      check("bp.hold.idx", 32'(bus8.out_idx), 32'd7);
      check("bp.hold.last", 32'(bus8.out_last), 32'd0);
      bus8.out_ready = 1'b1;
      tick();
      check("bp.b1.valid", 32'(bus8.out_valid), 32'd1);
      check("bp.b1.idx", 32'(bus8.out_idx), 32'd6);
      check("bp.b1.last", 32'(bus8.out_last), 32'd1);
      tick();
      check("bp.done.valid", 32'(bus8.out_valid), 32'd0);
      check("bp.done.in_ready", 32'(bus8.in_ready), 32'd1);

      // Reset mid-scan after the idx 5 beat is taken.
      bus8.in_vec   = 8'hFF;
      bus8.mode     = 1'b1;
      bus8.in_valid = 1'b1;
      tick();
      bus8.in_valid = 1'b0;
      check("rs.b0.idx", 32'(bus8.out_idx), 32'd7);
      tick();
      check("rs.b1.idx", 32'(bus8.out_idx), 32'd6);
      tick();
      check("rs.b2.idx", 32'(bus8.out_idx), 32'd5);
      tick();
      check("rs.b3.valid", 32'(bus8.out_valid), 32'd1);
      check("rs.b3.idx", 32'(bus8.out_idx), 32'd4);
      #2;
      rst = 1'b1;
      #1;
      check("rs.abort.valid", 32'(bus8.out_valid), 32'd0);
      check("rs.abort.idx", 32'(bus8.out_idx), 32'd0);
      check("rs.abort.in_ready", 32'(bus8.in_ready), 32'd0);
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("rs.rel.in_ready", 32'(bus8.in_ready), 32'd1);
      check("rs.rel.valid", 32'(bus8.out_valid), 32'd0);
      run8(8'b0000_1000, 1'b1, 1, 1'b0, 32'h0000_0003, "rs.after");

      // Width sweep on the N=5 instance.
      run5(5'b10000, 1, 32'h0000_0004, "n5a");
      run5(5'b00011, 2, 32'h0000_0001, "n5b");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
